reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Platform reset sequencer: holds all domains in reset until lock, then releases them in order.
// Optional calibration watchdog enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_GAP   = 16,
  parameter int CALIB_STAGE = 1,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mmcm_locked,
  input  logic                calib_done,
  input  logic                soft_rst_req,
  output logic                soft_rst_ack,
  output logic [N_STAGES-1:0] resetn_out,
  output logic                busy,
  output logic                seq_done,
  output logic                calib_timeout
);

  localparam int KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [15:0]   HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(STAGE_GAP - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(N_STAGES - 1);
  localparam logic [KW-1:0] K_CALIB   = KW'(CALIB_STAGE);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_ASSERT,
    S_RELEASE,
    S_GAP,
    S_WAIT_CALIB,
    S_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d, cnt_inc;
  logic [KW-1:0]         k_q, k_d;
  logic [N_STAGES-1:0]   resetn_q, resetn_d;
  logic [N_STAGES-1:0]   rel_mask;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic                  armed_q, armed_d;
  logic                  req_live;
  logic                  soft_fire;
  logic                  timeout_q, timeout_d;

  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign req_live = soft_rst_req & armed_q;

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_rel
    assign rel_mask[gi] = (state_q == S_RELEASE) && (k_q == KW'(gi));
  end

  // A request seen while holding reset is parked and only honoured once RUN is reached.
  always_comb begin
    soft_fire = 1'b0;
    if (state_q == S_RUN) begin
      soft_fire = req_live | pend_q;
    end else if (state_q == S_RELEASE || state_q == S_GAP || state_q == S_WAIT_CALIB) begin
      soft_fire = req_live & ~pend_q;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [20:0] WDOG_LAST = 21'(WDOG_CYCLES - 1);
  logic [20:0] wdog_q, wdog_d;
  logic        wdog_expired;

  always_comb begin
    wdog_d = 21'd0;
    if (state_q == S_WAIT_CALIB) begin
      wdog_d = (wdog_q == 21'h1FFFFF) ? wdog_q : wdog_q + 21'd1;
    end
  end

  assign wdog_expired = (state_q == S_WAIT_CALIB) && !calib_done && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 21'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic wdog_expired;
  logic unused_wdog;
  assign wdog_expired = 1'b0;
  assign unused_wdog  = ^WDOG_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    k_d       = k_q;
    ack_d     = 1'b0;
    pend_d    = pend_q;
    armed_d   = armed_q | ~soft_rst_req;
    timeout_d = timeout_q;

    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = 16'd0;
        k_d   = '0;
        if (req_live) pend_d = 1'b1;
        if (mmcm_locked) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (req_live) pend_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = 16'd0;
          k_d     = '0;
        end
      end
      S_RELEASE: begin
        cnt_d = 16'd0;
        if (k_q == K_LAST) begin
          state_d = S_RUN;
        end else if (k_q == K_CALIB) begin
          state_d = S_WAIT_CALIB;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = 16'd0;
          k_d     = k_q + 1'b1;
        end
      end
      S_WAIT_CALIB: begin
        cnt_d = 16'd0;
        if (calib_done) begin
          state_d = S_GAP;
        end else if (wdog_expired) begin
          state_d   = S_ASSERT;
          k_d       = '0;
          timeout_d = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = 16'd0;
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = 16'd0;
        k_d     = '0;
      end
    endcase

    if (soft_fire) begin
      state_d = S_ASSERT;
      cnt_d   = 16'd0;
      k_d     = '0;
      ack_d   = 1'b1;
      pend_d  = 1'b0;
      armed_d = 1'b0;
    end

    // Lock loss beats any soft request in the same cycle; the request is not consumed.
    if (state_q != S_WAIT_LOCK && !mmcm_locked) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = 16'd0;
      k_d     = '0;
      ack_d   = 1'b0;
      pend_d  = pend_q;
      armed_d = armed_q | ~soft_rst_req;
    end
  end

  always_comb begin
    resetn_d = resetn_q | rel_mask;
    if (state_d == S_WAIT_LOCK || state_d == S_ASSERT) begin
      resetn_d = '0;
    end else if (state_d == S_RUN) begin
      resetn_d = '1;
    end
    busy_d = (state_d != S_RUN);
    done_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_LOCK;
      cnt_q     <= 16'd0;
      k_q       <= '0;
      resetn_q  <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      armed_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      resetn_q  <= resetn_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      armed_q   <= armed_d;
      timeout_q <= timeout_d;
    end
  end

  assign resetn_out   = resetn_q;
  assign soft_rst_ack = ack_q;
  assign busy         = busy_q;
  assign seq_done     = done_q;

`ifdef RESET_SEQ_WATCHDOG_EN
  assign calib_timeout = timeout_q;
`else
  assign calib_timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected resetn edges and ack pulses are queued with their cycle.
module tb_reset_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mmcm_locked = 1'b0;
  logic         calib_done = 1'b0;
  logic         soft_rst_req = 1'b0;
  logic         soft_rst_ack;
  logic [N-1:0] resetn_out;
  logic         busy;
  logic         seq_done;
  logic         calib_timeout;

  reset_sequencer #(
    .N_STAGES(N), .HOLD_CYCLES(64), .STAGE_GAP(16), .CALIB_STAGE(1), .WDOG_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .mmcm_locked(mmcm_locked), .calib_done(calib_done),
    .soft_rst_req(soft_rst_req), .soft_rst_ack(soft_rst_ack), .resetn_out(resetn_out),
    .busy(busy), .seq_done(seq_done), .calib_timeout(calib_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] val;
    int           at;
  } ev_t;

  ev_t          exp_q[$];
  int           ack_exp_q[$];
  logic [N-1:0] prev_rn = '0;
  bit           mon_en = 1'b0;

  // One cycle: sample on the falling edge and match any resetn change or ack against the scoreboard.
  task automatic step();
    ev_t e;
    int  a;
    @(negedge clk);
    if (mon_en) begin
      if (resetn_out !== prev_rn) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resetn_unexpected cyc=%0d got=%b required no change from %b", cyc, resetn_out, prev_rn);
        end else begin
          e = exp_q.pop_front();
          if (resetn_out !== e.val || cyc != e.at) begin
            failures++;
            $display("FAIL resetn_edge got=%b@%0d required=%b@%0d", resetn_out, cyc, e.val, e.at);
          end
        end
      end
      if (soft_rst_ack === 1'b1) begin
        checks++;
        if (ack_exp_q.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected cyc=%0d got ack=1 required ack=0", cyc);
        end else begin
          a = ack_exp_q.pop_front();
          if (cyc != a) begin
            failures++;
            $display("FAIL ack_cycle got=%0d required=%0d", cyc, a);
          end
        end
      end
    end
    prev_rn = resetn_out;
  endtask

  task automatic push_ev(input logic [N-1:0] v, input int at);
    ev_t e;
    e.val = v;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Full release schedule with calib_done already high, relative to the cycle lock is first seen.
  task automatic push_seq(input int l);
    push_ev(4'b0001, l + 65);
    push_ev(4'b0011, l + 82);
    push_ev(4'b0111, l + 100);
    push_ev(4'b1111, l + 117);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || ack_exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || ack_exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d events outstanding after %0d cycles required 0",
               name, exp_q.size() + ack_exp_q.size(), budget);
    end
  endtask

  task automatic apply_reset(output int l);
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (5) step();
    exp_q.delete();
    ack_exp_q.delete();
    rst = 1'b0;
    mon_en = 1'b1;
    l = cyc + 1;
  endtask

  task automatic check_run(input string name);
    checks++;
    if (seq_done !== 1'b1 || busy !== 1'b0 || resetn_out !== 4'b1111) begin
      failures++;
      $display("FAIL %s_run got done=%b busy=%b rn=%b required done=1 busy=0 rn=1111",
               name, seq_done, busy, resetn_out);
    end
  endtask

  task automatic test_reset();
    mmcm_locked = 1'b1;
    calib_done = 1'b1;
    rst = 1'b1;
    mon_en = 1'b0;
    step();
    step();
    checks++;
    if (resetn_out !== 4'b0000 || busy !== 1'b1 || seq_done !== 1'b0 ||
        soft_rst_ack !== 1'b0 || calib_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got rn=%b busy=%b done=%b ack=%b to=%b required 0000 1 0 0 0",
               resetn_out, busy, seq_done, soft_rst_ack, calib_timeout);
    end
  endtask

  task automatic test_power_up();
    int l;
    mmcm_locked = 1'b1;
    calib_done = 1'b1;
    apply_reset(l);
    push_seq(l);
    drain(200, "power_up");
    check_run("power_up");
  endtask

  task automatic test_calib_wait();
    int l;
    int c;
    calib_done = 1'b0;
    apply_reset(l);
    push_ev(4'b0001, l + 65);
    push_ev(4'b0011, l + 82);
    drain(150, "calib_first");
    repeat (300) step();
    checks++;
    if (resetn_out !== 4'b0011 || busy !== 1'b1 || calib_timeout !== 1'b0) begin
      failures++;
      $display("FAIL calib_hold got rn=%b busy=%b to=%b required rn=0011 busy=1 to=0",
               resetn_out, busy, calib_timeout);
    end
    c = cyc;
    calib_done = 1'b1;
    push_ev(4'b0111, c + 18);
    push_ev(4'b1111, c + 35);
    drain(80, "calib_release");
    check_run("calib");
  endtask

  task automatic test_lock_loss();
    int c;
    c = cyc;
    mmcm_locked = 1'b0;
    push_ev(4'b0000, c + 1);
    step();
    checks++;
    if (busy !== 1'b1 || seq_done !== 1'b0) begin
      failures++;
      $display("FAIL lock_loss_flags got busy=%b done=%b required busy=1 done=0", busy, seq_done);
    end
    mmcm_locked = 1'b1;
    push_seq(c + 2);
    drain(200, "lock_loss");
    check_run("lock_loss");
  endtask

  task automatic test_soft_reset();
    int c;
    c = cyc;
    soft_rst_req = 1'b1;
    ack_exp_q.push_back(c + 1);
    push_ev(4'b0000, c + 1);
    push_seq(c + 1);
    repeat (10) step();
    soft_rst_req = 1'b0;
    drain(200, "soft_first");
    check_run("soft_first");
    step();
    c = cyc;
    soft_rst_req = 1'b1;
    ack_exp_q.push_back(c + 1);
    push_ev(4'b0000, c + 1);
    push_seq(c + 1);
    step();
    soft_rst_req = 1'b0;
    drain(200, "soft_rearm");
    check_run("soft_rearm");
  endtask

  task automatic test_back_to_back();
    int c;
    int acks = 0;
    step();
    c = cyc;
    soft_rst_req = 1'b1;
    ack_exp_q.push_back(c + 1);
    push_ev(4'b0000, c + 1);
    push_seq(c + 1);
    drain(200, "held_req");
    for (int i = 0; i < 20; i++) begin
      step();
      if (soft_rst_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL held_req_no_reack got %0d acks required 0", acks);
    end
    soft_rst_req = 1'b0;
    step();
    check_run("held_req");
  endtask

  task automatic test_simultaneous();
    int c;
    int l;
    // Soft request and lock loss together: lock loss wins, request dropped before relock.
    c = cyc;
    soft_rst_req = 1'b1;
    mmcm_locked = 1'b0;
    push_ev(4'b0000, c + 1);
    step();
    soft_rst_req = 1'b0;
    mmcm_locked = 1'b1;
    push_seq(c + 2);
    drain(200, "simul_lock");
    check_run("simul_lock");
    // Request still high in WAIT_LOCK is parked and acked only once RUN is reached.
    c = cyc;
    soft_rst_req = 1'b1;
    mmcm_locked = 1'b0;
    push_ev(4'b0000, c + 1);
    step();
    mmcm_locked = 1'b1;
    l = c + 2;
    step();
    soft_rst_req = 1'b0;
    push_seq(l);
    ack_exp_q.push_back(l + 118);
    push_ev(4'b0000, l + 118);
    push_seq(l + 118);
    drain(400, "pending");
    check_run("pending");
    // rst together with a soft request gives plain reset values.
    mon_en = 1'b0;
    rst = 1'b1;
    soft_rst_req = 1'b1;
    step();
    checks++;
    if (resetn_out !== 4'b0000 || soft_rst_ack !== 1'b0 || busy !== 1'b1 || seq_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_with_req got rn=%b ack=%b busy=%b done=%b required 0000 0 1 0",
               resetn_out, soft_rst_ack, busy, seq_done);
    end
    soft_rst_req = 1'b0;
    apply_reset(l);
    push_seq(l);
    drain(200, "rst_with_req");
    check_run("rst_with_req");
  endtask

  task automatic test_watchdog();
    int l;
    calib_done = 1'b0;
    apply_reset(l);
`ifdef RESET_SEQ_WATCHDOG_EN
    push_ev(4'b0001, l + 65);
    push_ev(4'b0011, l + 82);
    drain(150, "wdog_first");
    while (cyc < l + 1081) step();
    checks++;
    if (calib_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wdog_early got to=%b required 0 at cyc=%0d", calib_timeout, cyc);
    end
    push_ev(4'b0000, l + 1082);
    step();
    checks++;
    if (calib_timeout !== 1'b1 || resetn_out !== 4'b0000) begin
      failures++;
      $display("FAIL wdog_fire got to=%b rn=%b required to=1 rn=0000", calib_timeout, resetn_out);
    end
    calib_done = 1'b1;
    push_seq(l + 1082);
    drain(200, "wdog_retry");
    check_run("wdog_retry");
    checks++;
    if (calib_timeout !== 1'b1) begin
      failures++;
      $display("FAIL wdog_sticky got to=%b required 1", calib_timeout);
    end
`else
    push_ev(4'b0001, l + 65);
    push_ev(4'b0011, l + 82);
    drain(150, "nowdog_first");
    repeat (1200) step();
    checks++;
    if (calib_timeout !== 1'b0 || resetn_out !== 4'b0011) begin
      failures++;
      $display("FAIL nowdog_wait got to=%b rn=%b required to=0 rn=0011", calib_timeout, resetn_out);
    end
    calib_done = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_calib_wait();
    test_lock_loss();
    test_soft_reset();
    test_back_to_back();
    test_simultaneous();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got cyc=%0d required completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
